// File: rtl/sum_frame_sequencer_pkg.sv
// rtl/sum_frame_sequencer_pkg.sv - shared types and constants for the sum frame sequencer
package sum_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    WAIT_FREE,
    WAIT_ACK,
    WAIT_TX,
    DONE
  } state_t;

  localparam int         FRAME_LEN      = 5;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/sum_frame_sequencer_if.sv
// rtl/sum_frame_sequencer_if.sv - start-pulse/busy handshake towards the UART transmitter
interface sum_frame_sequencer_if;

  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;

  modport master (output uart_tx_en, output uart_tx_data, input uart_tx_busy);
  modport slave  (input uart_tx_en, input uart_tx_data, output uart_tx_busy);

endinterface

// File: rtl/sum_frame_sequencer_fall_edge_detect.sv
// rtl/sum_frame_sequencer_fall_edge_detect.sv - falling-edge pulse on an active-low request
module fall_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_sig_n,
  output logic o_fall
);

  logic r_prev;
  logic r_armed;

  // A request held low across reset release must not look like a fresh fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_sig_n;
      r_armed <= 1'b1;
    end
  end

  assign o_fall = r_prev & r_armed & ~i_sig_n;

endmodule

// File: rtl/sum_frame_sequencer.sv
// rtl/sum_frame_sequencer.sv - operand capture, registered sum and 5-byte frame sequencing into a UART
module sum_frame_sequencer
  import sum_frame_pkg::*;
#(
  parameter int         DATA_W      = 4,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  sum_frame_sequencer_if.master       uart,
  input  logic                        i_save_a_n,
  input  logic                        i_save_b_n,
  input  logic [DATA_W-1:0]           i_data_input,
  input  logic                        i_send_req,
  output logic [DATA_W-1:0]           o_operand_a,
  output logic [DATA_W-1:0]           o_operand_b,
  output logic [DATA_W:0]             o_sum,
  output logic                        o_frame_busy,
  output logic                        o_frame_done,
  output logic                        o_frame_err
);

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(FRAME_LEN - 1);

  state_t             r_state;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W:0]    r_sum;
  logic               r_tx_en;
  logic [7:0]         r_tx_data;
  logic [7:0]         r_chk;
  logic [2:0]         r_idx;
  logic [CNT_W-1:0]   r_ack_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_fall_a;
  logic               w_fall_b;
  logic [7:0]         w_byte;

  fall_edge_detect u_fall_a (
    .clk     (clk),
    .reset   (reset),
    .i_sig_n (i_save_a_n),
    .o_fall  (w_fall_a)
  );

  fall_edge_detect u_fall_b (
    .clk     (clk),
    .reset   (reset),
    .i_sig_n (i_save_b_n),
    .o_fall  (w_fall_b)
  );

  // Operands are frozen for the whole frame so the bytes stay consistent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
    end else begin
      if (w_fall_a && !r_busy) r_a <= i_data_input;
      if (w_fall_b && !r_busy) r_b <= i_data_input;
      r_sum <= {1'b0, r_a} + {1'b0, r_b};
    end
  end

  always_comb begin
    w_byte = HEADER;
    case (r_idx)
      3'd0:    w_byte = HEADER;
      3'd1:    w_byte = 8'(r_a);
      3'd2:    w_byte = 8'(r_b);
      3'd3:    w_byte = 8'(r_sum);
      default: w_byte = r_chk;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_chk     <= '0;
      r_idx     <= '0;
      r_ack_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tx_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_send_req) begin
            r_state <= PREP;
            r_busy  <= 1'b1;
          end
        end
        PREP: begin
          r_chk   <= '0;
          r_idx   <= '0;
          r_state <= WAIT_FREE;
        end
        WAIT_FREE: begin
          if (!uart.uart_tx_busy) begin
            r_tx_data <= w_byte;
            r_tx_en   <= 1'b1;
            r_chk     <= r_chk ^ w_byte;
            r_ack_cnt <= '0;
            r_state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (uart.uart_tx_busy) begin
            r_state <= WAIT_TX;
          end else if (r_ack_cnt == ACK_LAST) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end
        WAIT_TX: begin
          if (!uart.uart_tx_busy) begin
            if (r_idx == LAST_IDX) begin
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= WAIT_FREE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign uart.uart_tx_en   = r_tx_en;
  assign uart.uart_tx_data = r_tx_data;
  assign o_operand_a       = r_a;
  assign o_operand_b       = r_b;
  assign o_sum             = r_sum;
  assign o_frame_busy      = r_busy;
  assign o_frame_done      = r_done;
  assign o_frame_err       = r_err;

endmodule

// File: tb/tb_sum_frame_sequencer.sv
// tb/tb_sum_frame_sequencer.sv - scoreboard bench for sum_frame_sequencer with a UART busy model
module tb_sum_frame_sequencer;
  import sum_frame_pkg::*;

  localparam int DATA_W      = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int BUSY_LEN    = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              save_a_n, save_b_n, send_req;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W:0]   sum;
  logic              frame_busy, frame_done, frame_err;
  logic              force_busy = 1'b0;
  logic              model_busy = 1'b0;

  sum_frame_sequencer_if u_if ();
  assign u_if.uart_tx_busy = force_busy | model_busy;

  sum_frame_sequencer #(
    .DATA_W      (DATA_W),
    .HEADER      (8'hA5),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart         (u_if),
    .i_save_a_n   (save_a_n),
    .i_save_b_n   (save_b_n),
    .i_data_input (data_in),
    .i_send_req   (send_req),
    .o_operand_a  (op_a),
    .o_operand_b  (op_b),
    .o_sum        (sum),
    .o_frame_busy (frame_busy),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  logic [7:0]        exp_q[$];
  logic [DATA_W-1:0] m_a = '0;
  logic [DATA_W-1:0] m_b = '0;

  task automatic push_frame();
    logic [7:0] h, a, b, s;
    h = 8'hA5;
    a = 8'(m_a);
    b = 8'(m_b);
    s = 8'(m_a) + 8'(m_b);
    exp_q.push_back(h);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(s);
    exp_q.push_back(h ^ a ^ b ^ s);
  endtask

  int  en_cnt = 0, done_cnt = 0, err_cnt = 0;
  int  last_en_cyc = 0, last_err_cyc = 0, byte_no = 0, busy_left = 0;
  bit  ack_en = 1'b1, pending = 1'b0;
  logic prev_en = 1'b0;

  // UART model and output monitor share one block so busy is checked before it is raised.
  always @(negedge clk) begin
    if (u_if.uart_tx_en) begin
      en_cnt++;
      last_en_cyc = cyc;
      check_eq("en_while_busy", u_if.uart_tx_busy, 0);
      check_eq("en_back_to_back", prev_en, 0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_byte", u_if.uart_tx_data, 32'hFFFF_FFFF);
      end else begin
        check_eq($sformatf("byte%0d", byte_no), u_if.uart_tx_data, exp_q.pop_front());
      end
      byte_no++;
    end
    if (pending) begin
      model_busy = 1'b1;
      busy_left  = BUSY_LEN;
      pending    = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) model_busy = 1'b0;
    end
    if (u_if.uart_tx_en && ack_en) pending = 1'b1;
    prev_en = u_if.uart_tx_en;
    if (frame_done) done_cnt++;
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  task automatic save_a(input logic [DATA_W-1:0] v, input bit takes);
    @(negedge clk);
    data_in  = v;
    save_a_n = 1'b0;
    @(negedge clk);
    save_a_n = 1'b1;
    if (takes) m_a = v;
  endtask

  task automatic save_b(input logic [DATA_W-1:0] v, input bit takes);
    @(negedge clk);
    data_in  = v;
    save_b_n = 1'b0;
    @(negedge clk);
    save_b_n = 1'b1;
    if (takes) m_b = v;
  endtask

  task automatic send_frame(input bit accepted);
    @(negedge clk);
    send_req = 1'b1;
    if (accepted) push_frame();
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc);
    int d0 = done_cnt;
    int e0 = err_cnt;
    int n  = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_end_timeout", (done_cnt == d0 && err_cnt == e0), 0);
  endtask

  task automatic wait_en(input int target, input int max_cyc);
    int n = 0;
    while (en_cnt < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("en_wait_timeout", en_cnt >= target, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, e0, r0, c_rel;
    reset = 1'b1; save_a_n = 1'b1; save_b_n = 1'b1; data_in = '0; send_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_op_a", op_a, 0);
    check_eq("rst_op_b", op_b, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_en", u_if.uart_tx_en, 0);
    check_eq("rst_data", u_if.uart_tx_data, 0);
    check_eq("rst_busy", frame_busy, 0);
    check_eq("rst_done_err", {frame_done, frame_err}, 0);

    // basic frame
    save_a(4'h3, 1); save_b(4'h5, 1);
    repeat (2) @(negedge clk);
    check_eq("basic_op_a", op_a, 3);
    check_eq("basic_op_b", op_b, 5);
    check_eq("basic_sum", sum, 8);
    d0 = done_cnt; r0 = err_cnt; e0 = en_cnt;
    send_frame(1);
    check_eq("basic_busy_in_frame", frame_busy, 1);
    wait_end(400);
    repeat (3) @(negedge clk);
    check_eq("basic_done_once", done_cnt - d0, 1);
    check_eq("basic_no_err", err_cnt - r0, 0);
    check_eq("basic_en_count", en_cnt - e0, 5);
    check_eq("basic_busy_after", frame_busy, 0);
    check_eq("basic_q_empty", exp_q.size(), 0);

    // carry
    save_a(4'hF, 1); save_b(4'hF, 1);
    repeat (2) @(negedge clk);
    check_eq("carry_sum", sum, 5'h1E);
    d0 = done_cnt;
    send_frame(1);
    wait_end(400);
    @(negedge clk);
    check_eq("carry_done", done_cnt - d0, 1);
    check_eq("carry_q_empty", exp_q.size(), 0);

    // saves during a frame are ignored
    save_a(4'h3, 1); save_b(4'h5, 1);
    repeat (2) @(negedge clk);
    e0 = en_cnt;
    send_frame(1);
    wait_en(e0 + 1, 200);
    save_a(4'h7, 0);
    check_eq("frozen_op_a", op_a, 3);
    wait_end(400);
    @(negedge clk);
    check_eq("frozen_q_empty", exp_q.size(), 0);
    save_a(4'h7, 1);
    check_eq("after_done_op_a", op_a, 7);
    @(negedge clk);
    check_eq("after_done_sum", sum, 12);

    // ACK timeout
    ack_en = 1'b0;
    d0 = done_cnt; r0 = err_cnt; e0 = en_cnt;
    send_frame(1);
    wait_end(200);
    repeat (2) @(negedge clk);
    check_eq("to_err_once", err_cnt - r0, 1);
    check_eq("to_no_done", done_cnt - d0, 0);
    check_eq("to_one_en", en_cnt - e0, 1);
    check_eq("to_latency", last_err_cyc - last_en_cyc, ACK_TIMEOUT);
    check_eq("to_busy_clear", frame_busy, 0);
    check_eq("to_leftover", exp_q.size(), 4);
    exp_q.delete();
    ack_en = 1'b1;

    // UART busy at request time, plus an ignored second request
    force_busy = 1'b1;
    @(negedge clk);
    d0 = done_cnt; e0 = en_cnt;
    send_frame(1);
    repeat (10) @(negedge clk);
    check_eq("busy_start_no_en", en_cnt - e0, 0);
    check_eq("busy_start_frame_busy", frame_busy, 1);
    force_busy = 1'b0;
    c_rel = cyc;
    wait_en(e0 + 1, 50);
    check_eq("busy_start_first_free", last_en_cyc - c_rel, 1);
    wait_en(e0 + 3, 200);
    send_frame(0);
    wait_end(400);
    repeat (20) @(negedge clk);
    check_eq("busy_start_five_bytes", en_cnt - e0, 5);
    check_eq("busy_start_done", done_cnt - d0, 1);
    check_eq("busy_start_q_empty", exp_q.size(), 0);

    // reset in the middle of a frame
    d0 = done_cnt; r0 = err_cnt; e0 = en_cnt;
    send_frame(1);
    wait_en(e0 + 3, 200);
    @(negedge clk);
    reset = 1'b1; save_a_n = 1'b0; data_in = 4'h9;
    @(negedge clk);
    m_a = '0; m_b = '0;
    check_eq("mid_rst_en", u_if.uart_tx_en, 0);
    check_eq("mid_rst_busy", frame_busy, 0);
    check_eq("mid_rst_op_a", op_a, 0);
    check_eq("mid_rst_op_b", op_b, 0);
    check_eq("mid_rst_leftover", exp_q.size(), 2);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("held_save_no_latch", op_a, 0);
    save_a_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_no_done", done_cnt - d0, 0);
    check_eq("mid_rst_no_err", err_cnt - r0, 0);

    // normal frame after the abandoned one
    save_a(4'h1, 1); save_b(4'h2, 1);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    send_frame(1);
    wait_end(400);
    @(negedge clk);
    check_eq("post_rst_done", done_cnt - d0, 1);
    check_eq("final_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
